// File: rtl/count_arbiter.sv
// Two-requester round-robin scheduler for a shared up-counter. It grants the counter,
// clears it, runs it to the owner's latched terminal value, then pulses done.
module count_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_len0,
  input  logic [WIDTH-1:0] i_len1,
  input  logic [WIDTH-1:0] i_count,
  output logic [1:0]       o_grant,
  output logic [1:0]       o_done,
  output logic             o_busy,
  output logic             o_cnt_rst,
  output logic             o_cnt_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nxt;
  logic [1:0]       r_done;
  logic [1:0]       w_done_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             w_owner;
  logic             w_owner_req;
  logic             w_win;

  assign w_owner     = r_grant[1];
  assign w_owner_req = i_req[w_owner];
  // On a tie the requester that was not served last wins.
  assign w_win       = (i_req == 2'b11) ? ~r_last : i_req[1];

  always_comb begin
    w_next      = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_tgt_nxt   = r_tgt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_grant_nxt = w_win ? 2'b10 : 2'b01;
          w_tgt_nxt   = w_win ? i_len1 : i_len0;
          w_next      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!w_owner_req) begin
          w_next      = S_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = w_owner;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped request aborts even if the terminal count was reached this cycle.
        if (!w_owner_req) begin
          w_next      = S_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = w_owner;
        end else if (i_count == r_tgt) begin
          w_next     = S_DONE;
          w_done_nxt = r_grant;
        end
      end
      S_DONE: begin
        w_next      = S_IDLE;
        w_grant_nxt = '0;
        w_last_nxt  = w_owner;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_tgt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_tgt   <= w_tgt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_busy    = (r_state != S_IDLE);
  assign o_cnt_rst = i_rst | (r_state == S_CLEAR);
  assign o_cnt_en  = ~i_rst & (r_state == S_RUN) & (i_count != r_tgt);

endmodule
